// File: rtl/adc16dv160_input_read.sv
// ADC16DV160 capture block: AXI4-Lite read channel.
// Serves the CR/DSIZE/SR/SCNT/VER registers with one outstanding read,
// and owns the done/overflow sticky status bits that an SR read clears.

package adc16dv160_input_common;
    localparam logic [7:0] AXI_ADDR_CR    = 8'h00;
    localparam logic [7:0] AXI_ADDR_DSIZE = 8'h04;
    localparam logic [7:0] AXI_ADDR_SR    = 8'h08;
    localparam logic [7:0] AXI_ADDR_SCNT  = 8'h0C;
    localparam logic [7:0] AXI_ADDR_VER   = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

module adc16dv160_input_read #(
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [31:0] dsize,
    input  logic        cr_test,
    input  logic        busy,
    input  logic        done_pulse,
    input  logic        ovf_pulse,
    input  logic [31:0] sample_cnt
);
    import adc16dv160_input_common::*;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        done_sticky_q, done_sticky_d;
    logic        ovf_sticky_q, ovf_sticky_d;

    logic [7:0]  word_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        sr_sel;
    logic        ar_hs;
    logic        r_hs;

    // Address bits outside [7:2] carry no meaning for this register map.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{ARADDR[31:8], ARADDR[1:0]};

    assign word_addr = {ARADDR[7:2], 2'b00};
    assign ar_hs     = ARVALID && arready_q;
    assign r_hs      = rvalid_q && RREADY;

    // Register-map decode of the current address and live status inputs.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rd_data = '0;
        rd_resp = RESP_OKAY;
        sr_sel  = 1'b0;
        case (word_addr)
            AXI_ADDR_CR:    rd_data = {30'b0, cr_test, 1'b0};
            AXI_ADDR_DSIZE: rd_data = dsize;
            AXI_ADDR_SR: begin
                rd_data = {29'b0, ovf_sticky_q, done_sticky_q, busy};
                sr_sel  = 1'b1;
            end
            AXI_ADDR_SCNT:  rd_data = sample_cnt;
            AXI_ADDR_VER:   rd_data = VERSION;
            default:        rd_resp = RESP_SLVERR;
        endcase
    end

    // Next-state logic: read FSM, response capture and sticky status bits.
    always_comb begin
        state_d       = state_q;
        arready_d     = arready_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        done_sticky_d = done_sticky_q;
        ovf_sticky_d  = ovf_sticky_q;

        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d   = ST_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_data;
                    rresp_d   = rd_resp;
                end
            end
            ST_DATA: begin
                // Response stays frozen until the master takes it.
                if (r_hs) begin
                    state_d   = ST_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase

        // Clear on the SR read first, so a coincident pulse below wins.
        if (ar_hs && sr_sel) begin
            done_sticky_d = 1'b0;
            ovf_sticky_d  = 1'b0;
        end
        if (done_pulse) done_sticky_d = 1'b1;
        if (ovf_pulse)  ovf_sticky_d  = 1'b1;
    end

    // State registers; reset drops any pending response immediately.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            arready_q     <= 1'b1;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            done_sticky_q <= 1'b0;
            ovf_sticky_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            done_sticky_q <= done_sticky_d;
            ovf_sticky_q  <= ovf_sticky_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_adc16dv160_input_read.sv
// Self-checking bench for adc16dv160_input_read: a vector table of single
// reads plus hand-written sequences for sticky bits, back-pressure and reset.
// Expected responses are queued when the AR handshake is driven and compared
// when the R handshake happens.

module tb_adc16dv160_input_read;
    localparam logic [31:0] VERSION = 32'h0001_0000;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] dsize;
    logic        cr_test;
    logic        busy;
    logic        done_pulse;
    logic        ovf_pulse;
    logic [31:0] sample_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dsize;
        logic        cr_test;
        logic        busy;
        logic [31:0] scnt;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[9];

    adc16dv160_input_read #(.VERSION(VERSION)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .ARADDR     (ARADDR),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .dsize      (dsize),
        .cr_test    (cr_test),
        .busy       (busy),
        .done_pulse (done_pulse),
        .ovf_pulse  (ovf_pulse),
        .sample_cnt (sample_cnt)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur (got none, expected one)", name);
    endtask

    // One-cycle status pulse outside any read.
    task automatic pulse(input logic pd, input logic po);
        @(negedge ACLK);
        done_pulse = pd;
        ovf_pulse  = po;
        @(posedge ACLK);
        #1;
        done_pulse = 1'b0;
        ovf_pulse  = 1'b0;
    endtask

    // Drive an AR handshake (optionally with coincident pulses) and queue the expectation.
    task automatic ar_phase(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input logic pd, input logic po);
        int n;
        exp_t e;
        @(negedge ACLK);
        ARADDR     = addr;
        ARVALID    = 1'b1;
        done_pulse = pd;
        ovf_pulse  = po;
        n = 0;
        while (ARREADY !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (n == 20) fail_event("ar_ready_timeout");
        e.data = exp_data;
        e.resp = exp_resp;
        sb_q.push_back(e);
        @(posedge ACLK);
        #1;
        ARVALID    = 1'b0;
        done_pulse = 1'b0;
        ovf_pulse  = 1'b0;
    endtask

    // Hold off RREADY for 'stall' cycles (optionally poking inputs), then take the response.
    task automatic r_phase(input int stall, input logic poke);
        exp_t e;
        @(negedge ACLK);
        check("rvalid_one_cycle_after_ar", {31'b0, RVALID}, 32'd1);
        check("arready_low_in_data", {31'b0, ARREADY}, 32'd0);
        if (sb_q.size() == 0) begin
            fail_event("scoreboard_empty");
            return;
        end
        e = sb_q[0];
        for (int i = 0; i < stall; i++) begin
            check("stall_rvalid", {31'b0, RVALID}, 32'd1);
            check("stall_rdata", RDATA, e.data);
            check("stall_arready", {31'b0, ARREADY}, 32'd0);
            if (poke) begin
                ARVALID    = 1'b1;
                ARADDR     = 32'h10;
                sample_cnt = sample_cnt + 1;
            end
            @(negedge ACLK);
        end
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        e = sb_q.pop_front();
        check("rvalid_at_r_hs", {31'b0, RVALID}, 32'd1);
        check("rdata", RDATA, e.data);
        check("rresp", {30'b0, RRESP}, {30'b0, e.resp});
        @(posedge ACLK);
        #1;
        RREADY = 1'b0;
        check("arready_back_after_r_hs", {31'b0, ARREADY}, 32'd1);
        check("rvalid_drop_after_r_hs", {31'b0, RVALID}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        ar_phase(addr, exp_data, exp_resp, 1'b0, 1'b0);
        r_phase(0, 1'b0);
    endtask

    initial begin
        // addr, dsize, cr_test, busy, sample_cnt, expected data, expected resp
        vecs[0] = '{32'h04,  32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0000_1000, 2'b00};
        vecs[1] = '{32'h00,  32'h0,         1'b1, 1'b0, 32'h0,         32'h0000_0002, 2'b00};
        vecs[2] = '{32'h03,  32'h0,         1'b1, 1'b0, 32'h0,         32'h0000_0002, 2'b00};
        vecs[3] = '{32'h0C,  32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{32'h10,  32'h0,         1'b0, 1'b0, 32'h0,         VERSION,       2'b00};
        vecs[5] = '{32'h14,  32'h1234_5678, 1'b1, 1'b1, 32'h9,         32'h0,         2'b10};
        vecs[6] = '{32'hFC,  32'h1234_5678, 1'b1, 1'b1, 32'h9,         32'h0,         2'b10};
        vecs[7] = '{32'h108, 32'h0,         1'b0, 1'b1, 32'h0,         32'h0000_0001, 2'b00};
        vecs[8] = '{32'h08,  32'h0,         1'b0, 1'b0, 32'h0,         32'h0000_0000, 2'b00};

        ARESETN    = 1'b0;
        ARADDR     = '0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        dsize      = '0;
        cr_test    = 1'b0;
        busy       = 1'b0;
        done_pulse = 1'b0;
        ovf_pulse  = 1'b0;
        sample_cnt = '0;

        // Reset state.
        repeat (2) @(negedge ACLK);
        check("reset_arready", {31'b0, ARREADY}, 32'd1);
        check("reset_rvalid", {31'b0, RVALID}, 32'd0);
        check("reset_rdata", RDATA, 32'h0);
        check("reset_rresp", {30'b0, RRESP}, 32'd0);
        ARESETN = 1'b1;

        // Table of single reads.
        for (int i = 0; i < 9; i++) begin
            dsize      = vecs[i].dsize;
            cr_test    = vecs[i].cr_test;
            busy       = vecs[i].busy;
            sample_cnt = vecs[i].scnt;
            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end
        busy    = 1'b0;
        cr_test = 1'b0;

        // done sticky: set, read once, cleared by that read.
        pulse(1'b1, 1'b0);
        do_read(32'h08, 32'h2, 2'b00);
        do_read(32'h08, 32'h0, 2'b00);

        // ovf sticky survives non-SR and unmapped reads.
        pulse(1'b0, 1'b1);
        dsize = 32'h55;
        do_read(32'h04, 32'h55, 2'b00);
        do_read(32'hFC, 32'h0, 2'b10);
        do_read(32'h00, 32'h0, 2'b00);
        do_read(32'h08, 32'h4, 2'b00);
        do_read(32'h08, 32'h0, 2'b00);

        // ovf pulse coincident with the SR handshake: old value returned, bit stays set.
        ar_phase(32'h08, 32'h0, 2'b00, 1'b0, 1'b1);
        r_phase(0, 1'b0);
        do_read(32'h08, 32'h4, 2'b00);
        do_read(32'h08, 32'h0, 2'b00);

        // done pulse coincident with clearing an already-set done bit.
        pulse(1'b1, 1'b0);
        ar_phase(32'h08, 32'h2, 2'b00, 1'b1, 1'b0);
        r_phase(0, 1'b0);
        do_read(32'h08, 32'h2, 2'b00);
        do_read(32'h08, 32'h0, 2'b00);

        // All SR bits together.
        pulse(1'b1, 1'b1);
        busy = 1'b1;
        do_read(32'h08, 32'h7, 2'b00);
        busy = 1'b0;
        do_read(32'h08, 32'h0, 2'b00);

        // Back-pressure: response frozen while sample_cnt moves and ARVALID is ignored.
        sample_cnt = 32'd100;
        ar_phase(32'h0C, 32'd100, 2'b00, 1'b0, 1'b0);
        r_phase(5, 1'b1);

        // Reset in the middle of a read drops the response and the sticky bits.
        pulse(1'b1, 1'b1);
        ar_phase(32'h08, 32'h6, 2'b00, 1'b0, 1'b0);
        check("pre_reset_rvalid", {31'b0, RVALID}, 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("async_reset_rvalid", {31'b0, RVALID}, 32'd0);
        check("async_reset_arready", {31'b0, ARREADY}, 32'd1);
        check("async_reset_rdata", RDATA, 32'h0);
        sb_q.delete();
        @(negedge ACLK);
        ARESETN = 1'b1;
        do_read(32'h08, 32'h0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
